controle_tiro: RTL and testbench
================================

# controle_tiro

Shot sequencer for the player ship. It converts the raw fire key into single launch commands for the allied ball, keeps exactly one shot in flight, and detects the end of a shot from a collision flag or from the ball leaving the top of the screen. After each shot it enforces a reload delay. It sits between the key decoder and the allied `bola` instance and drives that instance's `iniciar_movimento`.

## Interface

Parameters:
- `COOLDOWN_CYCLES`, default 25_000_000 — reload length in unpaused clock cycles; legal range ≥1.
- `CONT_W`, default 25 — reload counter width; must satisfy 2^CONT_W ≥ COOLDOWN_CYCLES.
- `Y_TOPO`, default 0 — ball is out of screen when `y_bola` ≤ `Y_TOPO`.

Ports:
- `CLOCK_50`  in  1  — system clock.
- `resetNave`  in  1  — reset, asynchronous, active-high.
- `pausa`  in  1  — freezes state, counter and shot count while 1.
- `atirar`  in  1  — fire key level (`keysout[1]`).
- `bateu`  in  1  — allied ball collision flag (level or pulse).
- `y_bola`  in  10  — current allied ball y coordinate, unsigned.
- `iniciar_bola`  out  1  — launch/hold command to the ball; 1 while a shot is in flight.
- `pronto`  out  1  — 1 when a new shot is accepted (state IDLE).
- `tiros`  out  8  — shots fired since reset, saturating at 255.
- `estado`  out  2  — state code: IDLE=00, VOO=01, RECARGA=10; 11 is unused.

## Operation

- All outputs and internal state are registered and cleared asynchronously by `resetNave`:
  - `estado`=IDLE, `iniciar_bola`=0, `pronto`=1, `tiros`=0.
  - Counter = 0, `atirar_d` = 0.
- Edge detect: `atirar_d` samples `atirar` every cycle, including paused cycles. `fire_edge` = `atirar` & ~`atirar_d`. Holding the key fires at most once; the key must be released and pressed again.
- `pausa`=1: no state transition, no counter increment and no `tiros` change. Outputs hold their values. A `fire_edge` that occurs during pause is discarded.
- IDLE → VOO on `fire_edge` with `pausa`=0. On that transition `tiros` increments, saturating at 255.
- VOO → RECARGA when `bateu`=1 or `y_bola` ≤ `Y_TOPO`; either condition alone or both together cause one transition. `fire_edge` is ignored in VOO.
- RECARGA: the counter is cleared on entry and increments each unpaused cycle. When counter = `COOLDOWN_CYCLES`−1, the next state is IDLE. RECARGA therefore lasts exactly `COOLDOWN_CYCLES` unpaused cycles. `fire_edge` and `bateu` are ignored.
- `iniciar_bola` = (state == VOO). `pronto` = (state == IDLE). Both are derived from the registered state, so they are glitch-free.
- State code 11 is illegal and recovers to IDLE on the next unpaused cycle.

## Timing

- A `fire_edge` sampled at posedge n gives `estado`=VOO, `iniciar_bola`=1 and the incremented `tiros` after posedge n. Latency is 1 cycle.
- An end condition sampled at posedge m gives `iniciar_bola`=0 and `estado`=RECARGA after posedge m.
- The return to IDLE occurs `COOLDOWN_CYCLES` unpaused edges after entering RECARGA. `pronto`=1 follows on that edge.
- The minimum period between two accepted shots is 1 (VOO) + `COOLDOWN_CYCLES` + 1 (new edge) cycles.
- Reset asserted mid-flight or mid-reload forces IDLE immediately, without waiting for a clock edge. `iniciar_bola` drops asynchronously. The first edge after reset release is a normal cycle; a key already held at release fires once, because `atirar_d` resets to 0.

## Test plan

All scenarios use `COOLDOWN_CYCLES`=4 and `Y_TOPO`=5.

- **Basic shot:** from reset, `atirar` 0→1 at cycle 10 with `y_bola`=420 → after cycle 10: `estado`=01, `iniciar_bola`=1, `tiros`=1. Then `bateu`=1 at cycle 20 → `estado`=10 after 20 and `estado`=00, `pronto`=1 after cycle 24.
- **Held key:** `atirar` held high for 100 cycles, with `bateu` pulsed once in VOO → `tiros`=1 and no relaunch. Release, wait until `pronto`=1, press again → `tiros`=2.
- **Top exit:** in VOO, drive `y_bola` 6→5 → RECARGA on the cycle `y_bola`=5 is sampled. `y_bola`=6 alone keeps VOO.
- **Pause:** `pausa`=1 for 10 cycles mid-RECARGA → the counter freezes and IDLE arrives exactly 10 cycles later than without pause. A `fire_edge` during pause in IDLE → no shot and `tiros` unchanged.
- **Reset mid-operation:** assert `resetNave` between clock edges while in VOO → `iniciar_bola`=0, `estado`=00, `tiros`=0 immediately. With `atirar` held across the reset release → one shot fires on the first edge.
- **Saturation and simultaneity:** fire 256 shots → `tiros` stays at 255. Assert `bateu`=1 and `y_bola`=0 on the same cycle → a single transition to RECARGA and a 4-cycle reload.

Source files
------------

// File: rtl/controle_tiro.sv
// Shot sequencer for the player ship: turns fire-key presses into single launches
// of the allied ball, tracks the shot in flight and enforces a reload delay.
module controle_tiro #(
    parameter int COOLDOWN_CYCLES = 25_000_000,
    parameter int CONT_W          = 25,
    parameter int Y_TOPO          = 0
) (
    input  logic       CLOCK_50,
    input  logic       resetNave,
    input  logic       pausa,
    input  logic       atirar,
    input  logic       bateu,
    input  logic [9:0] y_bola,
    output logic       iniciar_bola,
    output logic       pronto,
    output logic [7:0] tiros,
    output logic [1:0] estado
);

    localparam logic [1:0] IDLE    = 2'b00;
    localparam logic [1:0] VOO     = 2'b01;
    localparam logic [1:0] RECARGA = 2'b10;

    localparam logic [CONT_W-1:0] CNT_FIM = CONT_W'(COOLDOWN_CYCLES - 1);
    localparam logic [CONT_W-1:0] CNT_UM  = CONT_W'(1);
    localparam logic [9:0]        Y_LIM   = 10'(Y_TOPO);

    logic [1:0]        estado_q, estado_d;
    logic [CONT_W-1:0] cont_q, cont_d;
    logic [7:0]        tiros_q, tiros_d;
    logic              atirarAnt_q;
    logic              fireEdge;
    logic              fimTiro;

    assign fireEdge = atirar & ~atirarAnt_q;
    assign fimTiro  = bateu | (y_bola <= Y_LIM);

    // Pause freezes everything except key sampling, so an edge seen while paused is lost.
    always_comb begin
        estado_d = estado_q;
        cont_d   = cont_q;
        tiros_d  = tiros_q;
        if (!pausa) begin
            case (estado_q)
                IDLE: begin
                    if (fireEdge) begin
                        estado_d = VOO;
                        if (tiros_q != 8'hFF) begin
                            tiros_d = tiros_q + 8'd1;
                        end
                    end
                end
                VOO: begin
                    if (fimTiro) begin
                        estado_d = RECARGA;
                        cont_d   = '0;
                    end
                end
                RECARGA: begin
                    if (cont_q == CNT_FIM) begin
                        estado_d = IDLE;
                    end else begin
                        cont_d = cont_q + CNT_UM;
                    end
                end
                default: estado_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or posedge resetNave) begin
        if (resetNave) begin
            estado_q    <= IDLE;
            cont_q      <= '0;
            tiros_q     <= '0;
            atirarAnt_q <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            cont_q      <= cont_d;
            tiros_q     <= tiros_d;
            atirarAnt_q <= atirar;
        end
    end

    // Decoded straight from the state register, so the ball command never glitches.
    assign iniciar_bola = (estado_q == VOO);
    assign pronto       = (estado_q == IDLE);
    assign tiros        = tiros_q;
    assign estado       = estado_q;

endmodule

// File: tb/tb_controle_tiro.sv
// Self-checking bench for controle_tiro: directed scenarios with literal expectations
// plus a randomized phase checked every cycle against a behavioural model.
module tb_controle_tiro;

    logic       CLOCK_50 = 1'b0;
    logic       resetNave = 1'b1;
    logic       pausa = 1'b0;
    logic       atirar = 1'b0;
    logic       bateu = 1'b0;
    logic [9:0] y_bola = 10'd420;
    logic       iniciar_bola;
    logic       pronto;
    logic [7:0] tiros;
    logic [1:0] estado;

    int nChecks = 0;
    int nFails  = 0;
    bit checkOn = 1'b0;

    controle_tiro #(
        .COOLDOWN_CYCLES(4),
        .CONT_W(3),
        .Y_TOPO(5)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .resetNave(resetNave),
        .pausa(pausa),
        .atirar(atirar),
        .bateu(bateu),
        .y_bola(y_bola),
        .iniciar_bola(iniciar_bola),
        .pronto(pronto),
        .tiros(tiros),
        .estado(estado)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Behavioural model: 0 = ready, 1 = flying, 2 = reloading with a countdown of cycles left.
    int mState = 0;
    int mReload = 0;
    int mShots = 0;
    bit mKeyPrev = 1'b0;
    bit keyEdge;
    bit shotEnds;

    assign keyEdge  = atirar && !mKeyPrev;
    assign shotEnds = bateu || (y_bola <= 10'd5);

    always @(posedge CLOCK_50 or posedge resetNave) begin
        if (resetNave) begin
            mState   <= 0;
            mReload  <= 0;
            mShots   <= 0;
            mKeyPrev <= 1'b0;
        end else begin
            mKeyPrev <= atirar;
            if (!pausa) begin
                if (mState == 0 && keyEdge) begin
                    mState <= 1;
                    mShots <= (mShots < 255) ? mShots + 1 : 255;
                end else if (mState == 1 && shotEnds) begin
                    mState  <= 2;
                    mReload <= 4;
                end else if (mState == 2) begin
                    mReload <= mReload - 1;
                    if (mReload == 1) mState <= 0;
                end
            end
        end
    end

    // Every cycle the outputs must agree with the model.
    always @(negedge CLOCK_50) begin
        if (checkOn) begin
            nChecks++;
            if (estado !== 2'(mState) || iniciar_bola !== (mState == 1) ||
                pronto !== (mState == 0) || tiros !== 8'(mShots)) begin
                nFails++;
                $display("[TB] FAIL model-compare t=%0t estado=%0d/%0d iniciar=%0b/%0b pronto=%0b/%0b tiros=%0d/%0d",
                         $time, estado, mState, iniciar_bola, mState == 1, pronto, mState == 0, tiros, mShots);
            end
        end
    end

    task automatic checkOutput(input string name, input int got, input int exp);
        nChecks++;
        if (got != exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic a, input logic b, input logic [9:0] y, input logic p);
        atirar = a;
        bateu  = b;
        y_bola = y;
        pausa  = p;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic doReset();
        applyStimulus(1'b0, 1'b0, 10'd420, 1'b0);
        resetNave = 1'b1;
        #2;
        resetNave = 1'b0;
    endtask

    initial begin
        #3;
        checkOutput("reset estado", estado, 0);
        checkOutput("reset iniciar", iniciar_bola, 0);
        checkOutput("reset pronto", pronto, 1);
        checkOutput("reset tiros", tiros, 0);
        resetNave = 1'b0;
        checkOn = 1'b1;
        tick(1);

        // Basic shot: launch, hit, four-cycle reload.
        tick(3);
        applyStimulus(1'b1, 1'b0, 10'd420, 1'b0);
        tick(1);
        checkOutput("basic estado voo", estado, 1);
        checkOutput("basic iniciar", iniciar_bola, 1);
        checkOutput("basic tiros", tiros, 1);
        applyStimulus(1'b0, 1'b1, 10'd420, 1'b0);
        tick(1);
        checkOutput("basic estado recarga", estado, 2);
        applyStimulus(1'b0, 1'b0, 10'd420, 1'b0);
        tick(3);
        checkOutput("basic still recarga", estado, 2);
        tick(1);
        checkOutput("basic back idle", estado, 0);
        checkOutput("basic pronto", pronto, 1);

        // Held key fires only once.
        doReset();
        for (int i = 0; i < 100; i++) begin
            applyStimulus(1'b1, i == 5, 10'd420, 1'b0);
            tick(1);
        end
        checkOutput("held tiros", tiros, 1);
        checkOutput("held estado", estado, 0);
        applyStimulus(1'b0, 1'b0, 10'd420, 1'b0);
        tick(1);
        for (int i = 0; i < 20 && !pronto; i++) tick(1);
        checkOutput("held pronto wait", pronto, 1);
        applyStimulus(1'b1, 1'b0, 10'd420, 1'b0);
        tick(1);
        checkOutput("held second shot", tiros, 2);

        // Top exit: y=6 keeps flying, y=5 ends the shot.
        doReset();
        applyStimulus(1'b1, 1'b0, 10'd6, 1'b0);
        tick(1);
        tick(5);
        checkOutput("top y6 voo", estado, 1);
        applyStimulus(1'b1, 1'b0, 10'd5, 1'b0);
        tick(1);
        checkOutput("top y5 recarga", estado, 2);

        // Pause mid-reload delays IDLE by exactly the paused cycles.
        doReset();
        applyStimulus(1'b1, 1'b0, 10'd420, 1'b0);
        tick(1);
        applyStimulus(1'b0, 1'b1, 10'd420, 1'b0);
        tick(1);
        applyStimulus(1'b0, 1'b0, 10'd420, 1'b0);
        tick(1);
        applyStimulus(1'b0, 1'b0, 10'd420, 1'b1);
        tick(10);
        checkOutput("pause frozen", estado, 2);
        applyStimulus(1'b0, 1'b0, 10'd420, 1'b0);
        tick(2);
        checkOutput("pause still recarga", estado, 2);
        tick(1);
        checkOutput("pause idle", estado, 0);

        // Key edge during pause in IDLE is discarded.
        applyStimulus(1'b1, 1'b0, 10'd420, 1'b1);
        tick(1);
        applyStimulus(1'b1, 1'b0, 10'd420, 1'b0);
        tick(2);
        checkOutput("pause edge tiros", tiros, 1);
        checkOutput("pause edge estado", estado, 0);

        // Asynchronous reset mid-flight, key held across release.
        doReset();
        applyStimulus(1'b1, 1'b0, 10'd420, 1'b0);
        tick(1);
        checkOutput("rst pre voo", estado, 1);
        #2;
        resetNave = 1'b1;
        #1;
        checkOutput("rst async iniciar", iniciar_bola, 0);
        checkOutput("rst async estado", estado, 0);
        checkOutput("rst async tiros", tiros, 0);
        #2;
        resetNave = 1'b0;
        tick(1);
        checkOutput("rst held fires", estado, 1);
        checkOutput("rst held tiros", tiros, 1);

        // Saturation at 255 shots.
        doReset();
        for (int s = 0; s < 256; s++) begin
            applyStimulus(1'b1, 1'b0, 10'd420, 1'b0);
            tick(1);
            applyStimulus(1'b0, 1'b1, 10'd420, 1'b0);
            tick(1);
            applyStimulus(1'b0, 1'b0, 10'd420, 1'b0);
            tick(4);
        end
        checkOutput("sat tiros", tiros, 255);

        // Simultaneous hit and top exit: one reload of four cycles.
        applyStimulus(1'b1, 1'b0, 10'd420, 1'b0);
        tick(1);
        applyStimulus(1'b0, 1'b1, 10'd0, 1'b0);
        tick(1);
        checkOutput("simul recarga", estado, 2);
        applyStimulus(1'b0, 1'b1, 10'd0, 1'b0);
        tick(3);
        checkOutput("simul still recarga", estado, 2);
        tick(1);
        checkOutput("simul idle", estado, 0);
        checkOutput("simul tiros sat", tiros, 255);

        // Randomized traffic, checked every cycle by the model compare.
        doReset();
        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0,
                          ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 10)) : 10'($urandom_range(6, 1023)),
                          $urandom_range(0, 9) == 0);
            if ($urandom_range(0, 299) == 0) begin
                #1;
                resetNave = 1'b1;
                #1;
                resetNave = 1'b0;
            end
            tick(1);
        end

        checkOn = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
